// File: rtl/uart_io_cmd_ctrl.sv
// uart_io_cmd_ctrl: UART command parser driving board outputs, with replies and key-event reporting
module uart_io_cmd_ctrl #(
  parameter int N_OUT       = 8,
  parameter int N_IN        = 4,
  parameter int TIMEOUT_CYC = 50_000_000
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             rx_done,
  input  logic [7:0]       rx_data,
  input  logic             tx_busy,
  output logic             tx_en,
  output logic [7:0]       tx_data,
  input  logic [N_IN-1:0]  key_in,
  output logic [N_OUT-1:0] out_pin,
  output logic             cmd_err
);
  typedef enum logic {P_IDLE, P_ARG} p_state_t;
  typedef enum logic [1:0] {T_IDLE, T_SEND, T_HOLD, T_WAIT} t_state_t;

  p_state_t         r_p_state, w_p_nxt;
  t_state_t         r_t_state, w_t_nxt;
  logic             r_rx_done_old;
  logic [N_IN-1:0]  r_key_old, r_pend, w_pend_clr;
  logic [7:0]       r_op, r_rep_byte, r_tx_byte, w_rep_byte, w_ld_byte, w_idx;
  logic [31:0]      r_tcnt;
  logic             r_rep_pend, r_sel_rep;
  logic             w_stb, w_arg_ok, w_op_ld, w_rep_set, w_err, w_ld, w_ld_rep, w_rep_clr;
  logic [N_OUT-1:0] w_mask, w_out_nxt;
  logic [2:0]       w_kidx;

  assign w_stb    = rx_done & ~r_rx_done_old;
  assign w_idx    = rx_data - 8'h31;
  assign w_arg_ok = rx_data >= 8'h31 && rx_data <= 8'h39 && 32'(w_idx) < N_OUT;
  assign w_mask   = N_OUT'(1) << w_idx[3:0];
  assign tx_data  = r_tx_byte;

  // Parser next state: opcode latch, argument apply, reply/error selection, argument timeout
  always_comb begin
    w_p_nxt    = r_p_state;
    w_out_nxt  = out_pin;
    w_op_ld    = 1'b0;
    w_rep_set  = 1'b0;
    w_rep_byte = 8'h6B;
    w_err      = 1'b0;
    if (r_p_state == P_IDLE) begin
      if (w_stb) begin
        if (rx_data == 8'h61 || rx_data == 8'h62 || rx_data == 8'h74) begin
          w_op_ld = 1'b1;
          w_p_nxt = P_ARG;
        end else if (rx_data == 8'h7A) begin
          w_out_nxt = '0;
          w_rep_set = 1'b1;
        end else if (rx_data != 8'h0D && rx_data != 8'h0A) begin
          w_rep_set  = 1'b1;
          w_rep_byte = 8'h3F;
          w_err      = 1'b1;
        end
      end
    end else if (w_stb) begin
      w_p_nxt   = P_IDLE;
      w_rep_set = 1'b1;
      if (w_arg_ok)
        w_out_nxt = r_op == 8'h61 ? out_pin | w_mask : r_op == 8'h62 ? out_pin & ~w_mask : out_pin ^ w_mask;
      else begin
        w_rep_byte = 8'h3F;
        w_err      = 1'b1;
      end
    end else if (r_tcnt == 32'(TIMEOUT_CYC - 1)) begin
      w_p_nxt = P_IDLE;
    end
  end

  // Parser registers: state, opcode, timeout counter (runs only while waiting for the argument), outputs
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_p_state <= P_IDLE;
      r_op      <= '0;
      r_tcnt    <= '0;
      out_pin   <= '0;
      cmd_err   <= 1'b0;
    end else begin
      r_p_state <= w_p_nxt;
      r_op      <= w_op_ld ? rx_data : r_op;
      r_tcnt    <= r_p_state == P_ARG ? r_tcnt + 32'd1 : '0;
      out_pin   <= w_out_nxt;
      cmd_err   <= w_err;
    end
  end

  // Lowest-index pending key event
  always_comb begin
    w_kidx = '0;
    for (int i = N_IN - 1; i >= 0; i--)
      if (r_pend[i]) w_kidx = 3'(i);
  end

  // TX next state: replies before key events, one strobe per byte, then wait out the transmitter
  always_comb begin
    w_t_nxt    = r_t_state;
    tx_en      = 1'b0;
    w_ld       = 1'b0;
    w_ld_rep   = 1'b0;
    w_ld_byte  = '0;
    w_pend_clr = '0;
    w_rep_clr  = 1'b0;
    if (r_t_state == T_IDLE) begin
      if (r_rep_pend) begin
        w_ld      = 1'b1;
        w_ld_rep  = 1'b1;
        w_ld_byte = r_rep_byte;
        w_t_nxt   = T_SEND;
      end else if (|r_pend) begin
        w_ld       = 1'b1;
        w_ld_byte  = 8'h61 + 8'(w_kidx);
        w_pend_clr = N_IN'(1) << w_kidx;
        w_t_nxt    = T_SEND;
      end
    end else if (r_t_state == T_SEND) begin
      tx_en     = 1'b1;
      w_rep_clr = r_sel_rep;
      w_t_nxt   = T_HOLD;
    end else if (r_t_state == T_HOLD) begin
      w_t_nxt = T_WAIT;
    end else if (!tx_busy) begin
      w_t_nxt = T_IDLE;
    end
  end

  // TX registers; a reply written while the old one is being taken stays pending so the newest wins
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_t_state <= T_IDLE;
      r_tx_byte <= '0;
      r_sel_rep <= 1'b0;
    end else begin
      r_t_state <= w_t_nxt;
      r_tx_byte <= w_ld ? w_ld_byte : r_tx_byte;
      r_sel_rep <= w_ld ? w_ld_rep & ~w_rep_set : r_sel_rep;
    end
  end

  // Edge history, key-event mask (set beats clear) and the single reply slot (set beats clear)
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_rx_done_old <= 1'b0;
      r_key_old     <= '0;
      r_pend        <= '0;
      r_rep_pend    <= 1'b0;
      r_rep_byte    <= '0;
    end else begin
      r_rx_done_old <= rx_done;
      r_key_old     <= key_in;
      r_pend        <= (r_pend & ~w_pend_clr) | (r_key_old & ~key_in);
      r_rep_pend    <= w_rep_set | (r_rep_pend & ~w_rep_clr);
      r_rep_byte    <= w_rep_set ? w_rep_byte : r_rep_byte;
    end
  end
endmodule

// File: tb/tb_uart_io_cmd_ctrl.sv
// tb_uart_io_cmd_ctrl: scoreboard bench for the UART command/status controller
module tb_uart_io_cmd_ctrl;
  localparam int T = 20;

  logic       sys_clk = 1'b0, sys_rst_n = 1'b0, rx_done = 1'b0, tx_busy = 1'b0;
  logic [7:0] rx_data = '0;
  logic [3:0] key_in = 4'hF;
  logic       tx_en, cmd_err;
  logic [7:0] tx_data, out_pin;
  int         n_err = 0, n_chk = 0, cyc = 0, last_tx = -100, n_cerr = 0;
  logic [7:0] sb[$];

  uart_io_cmd_ctrl #(.N_OUT(8), .N_IN(4), .TIMEOUT_CYC(T)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx_done(rx_done), .rx_data(rx_data),
    .tx_busy(tx_busy), .tx_en(tx_en), .tx_data(tx_data), .key_in(key_in),
    .out_pin(out_pin), .cmd_err(cmd_err)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(negedge sys_clk) if (sys_rst_n) begin
    if (cmd_err) n_cerr++;
    if (tx_en) begin
      chk("tx_gap", 32'(cyc - last_tx >= 4), 1);
      last_tx = cyc;
      if (sb.size() == 0) chk("tx_extra", {24'd0, tx_data}, 32'hFFFF_FFFF);
      else chk("tx_byte", {24'd0, tx_data}, {24'd0, sb.pop_front()});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge sys_clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge sys_clk);
    rx_done = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 2000 && sb.size() != 0; i++) @(negedge sys_clk);
    chk("drain", 32'(sb.size()), 0);
    tick(4);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tick(3);
    chk("rst_out", out_pin, 0);
    chk("rst_tx_en", tx_en, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_err", cmd_err, 0);
    sys_rst_n = 1'b1;
    tick(2);
    send("a"); send("3"); chk("set3", out_pin, 8'h04); sb.push_back(8'h6B); drain();
    send("t"); send("3"); chk("tog3", out_pin, 8'h00); sb.push_back(8'h6B); drain();
    send("t"); send("1"); chk("tog1", out_pin, 8'h01); sb.push_back(8'h6B); drain();
    send("a"); send("9"); chk("bad_idx_out", out_pin, 8'h01); chk("bad_idx_err", cmd_err, 1);
    sb.push_back(8'h3F); drain();
    send("x"); chk("bad_op_err", cmd_err, 1); chk("bad_op_out", out_pin, 8'h01);
    sb.push_back(8'h3F); drain();
    send("a"); send("2"); chk("set2", out_pin, 8'h03); sb.push_back(8'h6B); drain();
    send("b"); tick(T - 2); send("2"); chk("last_cycle_arg", out_pin, 8'h01); sb.push_back(8'h6B); drain();
    send("a"); send("4"); chk("set4", out_pin, 8'h09); sb.push_back(8'h6B); drain();
    send("b"); tick(T - 1); send("z"); chk("timeout_z_out", out_pin, 8'h00); chk("timeout_err", cmd_err, 0);
    sb.push_back(8'h6B); drain();
    chk("err_cnt_a", n_cerr, 2);
    tx_busy = 1'b1;
    send("z"); sb.push_back(8'h6B);
    tick(10);
    key_in = 4'b1010; tick(3); key_in = 4'hF; tick(3);
    key_in = 4'b1110; tick(3); key_in = 4'hF;
    send("a"); send("1"); chk("busy_set1", out_pin, 8'h01);
    sb.push_back(8'h6B); sb.push_back(8'h61); sb.push_back(8'h63);
    tick(1000);
    chk("busy_held", 32'(sb.size()), 3);
    tx_busy = 1'b0;
    drain();
    send("a"); tick(1);
    sys_rst_n = 1'b0; #1;
    chk("rst_arg_out", out_pin, 0);
    chk("rst_arg_tx_data", tx_data, 0);
    chk("rst_arg_tx_en", tx_en, 0);
    tick(2); sys_rst_n = 1'b1; tick(2);
    send("1"); chk("after_rst_arg_err", cmd_err, 1); chk("after_rst_arg_out", out_pin, 0);
    sb.push_back(8'h3F); drain();
    send("a"); send("2"); chk("set2b", out_pin, 8'h02); sb.push_back(8'h6B);
    tx_busy = 1'b1;
    drain();
    key_in = 4'b1101;
    sys_rst_n = 1'b0; #1;
    chk("rst_wait_out", out_pin, 0);
    chk("rst_wait_tx_data", tx_data, 0);
    tick(2); sys_rst_n = 1'b1; tx_busy = 1'b0; tick(3);
    key_in = 4'hF; tick(3);
    send("1"); chk("after_rst_wait_err", cmd_err, 1); sb.push_back(8'h3F); drain();
    tick(5);
    chk("err_cnt_b", n_cerr, 4);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/uart_io_cmd_ctrl.md
# uart_io_cmd_ctrl

Parametrised UART command/status controller between the `uart_hs` byte interface and board I/O. It decodes two-byte ASCII commands (set, clear or toggle one of `N_OUT` outputs) and single-byte commands (clear all). It acknowledges every command over UART TX and reports falling edges on `N_IN` debounced, active-low keys as ASCII event bytes. It replaces the fixed 4-LED / 4-key matcher pair and adds toggle, a command timeout, replies and lossless key-event queuing.

## Interface
- `N_OUT`, default 8, number of controlled outputs; legal range 1..9.
- `N_IN`, default 4, number of key inputs; legal range 1..8.
- `TIMEOUT_CYC`, default 50_000_000, number of cycles the parser waits for an argument byte before abandoning a command; must be ≥2.

Ports (clock and reset first):
- `sys_clk` in 1: clock.
- `sys_rst_n` in 1: reset, asynchronous, active-low. Reset sys_rst_n, asynchronous, active-low; clock sys_clk.
- `rx_done` in 1: UART receive-done level; a byte is accepted on its rising edge.
- `rx_data` in 8: received byte, valid while `rx_done` = 1.
- `tx_busy` in 1: UART transmitter busy.
- `tx_en` out 1: one-cycle send strobe.
- `tx_data` out 8: byte to send; held after the strobe.
- `key_in` in N_IN: debounced keys; idle = 1, pressed = 0.
- `out_pin` out N_OUT: controlled outputs.
- `cmd_err` out 1: one-cycle pulse on every rejected command.

## Operation
- Reset values: `out_pin` = 0, `tx_en` = 0, `tx_data` = 0, `cmd_err` = 0. Parser in IDLE, TX FSM in IDLE. Key-event pending mask = 0, reply pending = 0. `rx_done_old` = 0, `key_old` = 0.
- Byte strobe: `rx_done` = 1 and `rx_done_old` = 0. `rx_done_old` is registered every cycle.
- Parser FSM (IDLE, ARG), on a byte strobe:
  - In IDLE, 'a' (0x61), 'b' (0x62) or 't' (0x74): latch the opcode, clear the timeout counter, go to ARG.
  - In IDLE, 'z' (0x7A): `out_pin` ← 0 and queue reply 'k' (0x6B).
  - In IDLE, CR (0x0D) or LF (0x0A): ignored, no reply.
  - In IDLE, any other byte: queue reply '?' (0x3F) and pulse `cmd_err`.
  - In ARG, byte d in '1'..'9' with idx = d−0x31 < N_OUT: 'a' sets, 'b' clears, 't' inverts `out_pin[idx]`. Queue 'k'. Go to IDLE.
  - In ARG, any other byte (including idx ≥ N_OUT): no output change, queue '?', pulse `cmd_err`, go to IDLE.
- Timeout: the counter runs only in ARG. When it reaches TIMEOUT_CYC−1 with no strobe, go to IDLE with no reply and no `cmd_err`. A strobe in that same cycle takes precedence and is processed as the argument byte.
- Reply slot: a single register. A new reply queued while one is still pending overwrites it, so the newest reply wins.
- Key events:
  - `key_old` is registered every cycle.
  - A falling edge (`key_old[i]` = 1, `key_in[i]` = 0) sets `pend[i]`.
  - A key held low through reset release produces no event.
  - A set and a clear of `pend[i]` in the same cycle leave it set, so events are never lost; repeated presses before a bit is sent merge into one event.
  - Event byte for key i is 0x61+i.
- TX FSM (IDLE, SEND, HOLD, WAIT):
  - IDLE: if a reply is pending, select it and go to SEND. Otherwise, if any `pend` bit is set, select the lowest index i, clear `pend[i]`, go to SEND. Replies always take priority.
  - SEND: drive `tx_en` = 1 and `tx_data` = the selected byte; clear the reply slot if the reply was selected. Go to HOLD.
  - HOLD: one cycle, `tx_busy` ignored. Go to WAIT.
  - WAIT: stay while `tx_busy` = 1; go to IDLE when `tx_busy` = 0.
- A reply queued during SEND, HOLD or WAIT is sent on the next IDLE pass.
- Reset asserted mid-command or mid-transmission returns every register to its reset value at once. A partial command is discarded.

## Timing
- `out_pin` and `cmd_err` change on the first clock edge after the cycle in which `rx_done` is first sampled high (latency 1).
- Reply queued in cycle n: if the TX FSM is in IDLE at cycle n+1, `tx_en` is high in cycle n+2.
- Key edge sampled in cycle n: with the TX FSM idle and no reply pending, `tx_en` is high in cycle n+2.
- Minimum spacing between `tx_en` pulses is 4 cycles (SEND, HOLD, WAIT, IDLE).
- `tx_en` is never high in two consecutive cycles.
- `tx_data` is stable from SEND until the next SEND.

## Test plan
- After reset, bytes 'a','3' → `out_pin` = 0x04 one cycle after the second strobe; TX sends 0x6B.
- With `out_pin` = 0x04: bytes 't','3' then 't','1' → `out_pin` = 0x00, then 0x01; two 0x6B bytes sent.
- With N_OUT = 8: bytes 'a','9' → `out_pin` unchanged, `cmd_err` pulses once, TX sends 0x3F. Byte 'x' → same response.
- Byte 'b', then no byte for TIMEOUT_CYC cycles, then 'z' → no reply for the 'b'; `out_pin` = 0; one 0x6B sent.
- With `tx_busy` forced high for 1000 cycles: `key_in[2]` and `key_in[0]` fall in the same cycle, and 'a','1' is received → once `tx_busy` drops, TX sends 0x6B, then 0x61, then 0x63. No event is lost; `tx_en` pulses are ≥4 cycles apart.
- `sys_rst_n` asserted in ARG and during WAIT → all outputs return to 0 immediately; after release, a single '1' byte returns '?'.
